// File: rtl/cmd_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_decode_queue
//  Description : Trace-command decode queue. Accepts {cmd, addr} trace
//                commands, drops illegal codes with a one-cycle pulse,
//                buffers legal ones in a circular queue, and presents the
//                head split into tag/index/offset fields with snoop/control
//                classification. Keeps saturating read/write/illegal
//                statistics that a CLR command zeroes.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_decode_queue #(
    parameter int DEPTH        = 4,
    parameter int ADDRESS_BITS = 32,
    parameter int OFFSET_BITS  = 6,
    parameter int INDEX_BITS   = 11,
    parameter int TAG_BITS     = ADDRESS_BITS - (INDEX_BITS + OFFSET_BITS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_cmd,
    input  logic [ADDRESS_BITS-1:0]    in_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_cmd,
    output logic [TAG_BITS-1:0]        out_tag,
    output logic [INDEX_BITS-1:0]      out_index,
    output logic [OFFSET_BITS-1:0]     out_offset,
    output logic                       out_is_snoop,
    output logic                       out_is_ctrl,
    output logic                       illegal_cmd,
    output logic [31:0]                read_cnt,
    output logic [31:0]                write_cnt,
    output logic [31:0]                illegal_cnt,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OCC_W = $clog2(DEPTH) + 1;

    // Queue storage; contents need no reset because out_valid gates them.
    logic [3:0]              r_mem_cmd  [DEPTH];
    logic [ADDRESS_BITS-1:0] r_mem_addr [DEPTH];

    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_OCC_W-1:0]      r_occ;
    logic                    r_illegal;
    logic [31:0]             r_read_cnt;
    logic [31:0]             r_write_cnt;
    logic [31:0]             r_illegal_cnt;

    logic                    w_full;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_legal;
    logic                    w_enq;
    logic [3:0]              w_head_cmd;
    logic [ADDRESS_BITS-1:0] w_head_addr;

    // Full blocks acceptance outright; a same-cycle pop never makes room.
    assign w_full    = (r_occ == c_OCC_W'(DEPTH));
    assign in_ready  = !w_full && !rst;
    assign w_push    = in_valid && in_ready;
    assign out_valid = (r_occ != '0);
    assign w_pop     = out_valid && out_ready;
    assign w_enq     = w_push && w_legal;

    // Legal code decode: 7 and 10-15 are accepted but dropped.
    always_comb begin
        w_legal = 1'b0;
        case (in_cmd)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd8, 4'd9: w_legal = 1'b1;
            default:                w_legal = 1'b0;
        endcase
    end

    // Write accepted legal commands at the tail.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_cmd[r_wr_ptr]  <= in_cmd;
            r_mem_addr[r_wr_ptr] <= in_addr;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_enq, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_W'(1);
                2'b01:   r_occ <= r_occ - c_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Statistics and illegal pulse, updated at acceptance time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal     <= 1'b0;
            r_read_cnt    <= '0;
            r_write_cnt   <= '0;
            r_illegal_cnt <= '0;
        end else begin
            r_illegal <= w_push && !w_legal;
            if (w_push) begin
                case (in_cmd)
                    4'd0, 4'd2: if (r_read_cnt  != '1) r_read_cnt  <= r_read_cnt  + 32'd1;
                    4'd1:       if (r_write_cnt != '1) r_write_cnt <= r_write_cnt + 32'd1;
                    4'd8: begin
                        r_read_cnt    <= '0;
                        r_write_cnt   <= '0;
                        r_illegal_cnt <= '0;
                    end
                    default: begin
                        if (!w_legal && (r_illegal_cnt != '1))
                            r_illegal_cnt <= r_illegal_cnt + 32'd1;
                    end
                endcase
            end
        end
    end

    assign w_head_cmd   = r_mem_cmd[r_rd_ptr];
    assign w_head_addr  = r_mem_addr[r_rd_ptr];

    assign out_cmd      = w_head_cmd;
    assign out_tag      = w_head_addr[ADDRESS_BITS-1 -: TAG_BITS];
    assign out_index    = w_head_addr[OFFSET_BITS +: INDEX_BITS];
    assign out_offset   = w_head_addr[OFFSET_BITS-1:0];
    assign out_is_snoop = out_valid && (w_head_cmd inside {4'd3, 4'd4, 4'd5, 4'd6});
    assign out_is_ctrl  = out_valid && (w_head_cmd inside {4'd8, 4'd9});

    assign illegal_cmd  = r_illegal;
    assign read_cnt     = r_read_cnt;
    assign write_cnt    = r_write_cnt;
    assign illegal_cnt  = r_illegal_cnt;
    assign occupancy    = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_cmd_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_decode_queue
//  Description : Self-checking bench for cmd_decode_queue: directed scenarios
//                followed by randomized traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd;
    logic [31:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_cmd;
    logic [14:0] out_tag;
    logic [10:0] out_index;
    logic [5:0]  out_offset;
    logic        out_is_snoop;
    logic        out_is_ctrl;
    logic        illegal_cmd;
    logic [31:0] read_cnt;
    logic [31:0] write_cnt;
    logic [31:0] illegal_cnt;
    logic [2:0]  occupancy;

    cmd_decode_queue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
        .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
        .out_is_snoop(out_is_snoop), .out_is_ctrl(out_is_ctrl),
        .illegal_cmd(illegal_cmd),
        .read_cnt(read_cnt), .write_cnt(write_cnt), .illegal_cnt(illegal_cnt),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a FIFO of accepted legal commands plus counters.
    typedef struct { logic [3:0] cmd; logic [31:0] addr; } ent_t;
    ent_t   mq[$];
    longint m_rd, m_wr, m_il;
    bit     m_ill_pulse;
    localparam longint SAT = 64'hFFFF_FFFF;

    function automatic bit is_legal(input logic [3:0] c);
        return (c <= 4'd6) || (c == 4'd8) || (c == 4'd9);
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic model_update(input bit r, input bit v, input logic [3:0] c,
                                input logic [31:0] a, input bit ordy);
        bit acc;
        if (r) begin
            mq.delete();
            m_rd = 0; m_wr = 0; m_il = 0; m_ill_pulse = 0;
            return;
        end
        acc = v && (mq.size() < DEPTH);
        if (ordy && mq.size() > 0) void'(mq.pop_front());
        m_ill_pulse = acc && !is_legal(c);
        if (acc) begin
            if (is_legal(c)) mq.push_back('{cmd: c, addr: a});
            if (c == 4'd0 || c == 4'd2) m_rd = sat_inc(m_rd);
            else if (c == 4'd1)         m_wr = sat_inc(m_wr);
            else if (c == 4'd8)         begin m_rd = 0; m_wr = 0; m_il = 0; end
            else if (!is_legal(c))      m_il = sat_inc(m_il);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid",   out_valid,   mq.size() != 0);
        chk("occupancy",   occupancy,   mq.size());
        chk("illegal_cmd", illegal_cmd, m_ill_pulse);
        chk("read_cnt",    read_cnt,    m_rd);
        chk("write_cnt",   write_cnt,   m_wr);
        chk("illegal_cnt", illegal_cnt, m_il);
        if (mq.size() != 0) begin
            chk("out_cmd",      out_cmd,      mq[0].cmd);
            chk("out_tag",      out_tag,      mq[0].addr / (1 << 17));
            chk("out_index",    out_index,    (mq[0].addr / 64) % 2048);
            chk("out_offset",   out_offset,   mq[0].addr % 64);
            chk("out_is_snoop", out_is_snoop, mq[0].cmd >= 3 && mq[0].cmd <= 6);
            chk("out_is_ctrl",  out_is_ctrl,  mq[0].cmd == 8 || mq[0].cmd == 9);
        end
    endtask

    // One clock cycle: drive at the falling edge, check after the next one.
    task automatic step(input bit r, input bit v, input logic [3:0] c,
                        input logic [31:0] a, input bit ordy);
        rst = r; in_valid = v; in_cmd = c; in_addr = a; out_ready = ordy;
        #1;
        chk("in_ready", in_ready, (mq.size() < DEPTH) && !r);
        @(posedge clk);
        model_update(r, v, c, a, ordy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cmd = '0; in_addr = '0; out_ready = 1'b0;
        mq.delete(); m_rd = 0; m_wr = 0; m_il = 0; m_ill_pulse = 0;
        @(negedge clk);

        // Reset state
        do_reset();
        do_reset();
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Single read push and address field split
        step(1'b0, 1'b1, 4'd0, 32'h1234_5678, 1'b0);
        chk("d1_tag",    out_tag,    15'h091A);
        chk("d1_index",  out_index,  11'h159);
        chk("d1_offset", out_offset, 6'h38);
        chk("d1_rdcnt",  read_cnt,   32'd1);

        // Fill to full, fifth held off, one pop frees a slot
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'd1, $urandom, 1'b0);
        chk("d2_occ_full", occupancy, 3'd4);
        step(1'b0, 1'b1, 4'd2, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
        #1;
        chk("d2_ready_after_pop", in_ready, 1'b1);

        // Illegal codes dropped
        do_reset();
        step(1'b0, 1'b1, 4'd7,  32'hAAAA_0000, 1'b0);
        step(1'b0, 1'b1, 4'd12, 32'h5555_0000, 1'b0);
        step(1'b0, 1'b0, 4'd0,  32'd0, 1'b0);
        chk("d3_illcnt", illegal_cnt, 32'd2);
        chk("d3_empty",  out_valid,   1'b0);

        // Streaming across pointer wrap
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'(i % 7), $urandom, 1'b1);
        chk("d4_occ", occupancy, 3'd1);

        // Counters then CLR
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd0, $urandom, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 4'd1, $urandom, 1'b1);
        chk("d5_rd", read_cnt,  32'd3);
        chk("d5_wr", write_cnt, 32'd2);
        step(1'b0, 1'b1, 4'd8, 32'h0000_0040, 1'b1);
        chk("d5_rd_clr", read_cnt,    32'd0);
        chk("d5_wr_clr", write_cnt,   32'd0);
        chk("d5_ctrl",   out_is_ctrl, 1'b1);
        chk("d5_cmd",    out_cmd,     4'd8);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd2, $urandom, 1'b0);
        step(1'b1, 1'b1, 4'd0, 32'h1111_1111, 1'b0);
        chk("d6_occ",   occupancy, 3'd0);
        chk("d6_valid", out_valid, 1'b0);
        chk("d6_rd",    read_cnt,  32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7,
                 c, $urandom,
                 $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
